// File: rtl/constraint_sampler_pkg.sv
// Shared types and constants for the constraint sampler transmit side.
// Optional statistics outputs are enabled with the SAMPLER_STATS_EN macro (see constraint_sampler_tx).
package constraint_sampler_pkg;

    localparam int VAR0_W   = 13;
    localparam int VAR1_W   = 13;
    localparam int VAR2_W   = 14;
    localparam int VAR3_W   = 14;
    localparam int VAR4_W   = 8;
    localparam int SAMPLE_W = VAR0_W + VAR1_W + VAR2_W + VAR3_W + VAR4_W;

    localparam int LFSR_W = 64;
    // Galois right-shift mask for x^64 + x^63 + x^61 + x^60 + 1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        TRY,
        EMIT,
        DONE
    } state_t;

    // Packed so that a cast of LFSR bits [61:0] yields the candidate slices directly
    typedef struct packed {
        logic [VAR4_W-1:0] var_4;
        logic [VAR3_W-1:0] var_3;
        logic [VAR2_W-1:0] var_2;
        logic [VAR1_W-1:0] var_1;
        logic [VAR0_W-1:0] var_0;
    } sample_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ ({LFSR_W{s[0]}} & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/constraint_sampler_if.sv
// Accepted-sample valid/ready stream between the sampler and the sample sink.
interface constraint_sampler_if;
    import constraint_sampler_pkg::*;

    logic              samp_valid;
    logic              samp_ready;
    logic [VAR0_W-1:0] samp_var_0;
    logic [VAR1_W-1:0] samp_var_1;
    logic [VAR2_W-1:0] samp_var_2;
    logic [VAR3_W-1:0] samp_var_3;
    logic [VAR4_W-1:0] samp_var_4;

    modport master (
        output samp_valid, samp_var_0, samp_var_1, samp_var_2, samp_var_3, samp_var_4,
        input  samp_ready
    );

    modport slave (
        input  samp_valid, samp_var_0, samp_var_1, samp_var_2, samp_var_3, samp_var_4,
        output samp_ready
    );

endinterface

// File: rtl/sampler_lfsr.sv
// 64-bit Galois LFSR with synchronous load; a zero seed is replaced by 1
// so the register can never lock up in the all-zero state.
module sampler_lfsr
    import constraint_sampler_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              step_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    // Next state: load has priority over step; otherwise hold
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == '0) ? LFSR_W'(1) : seed_i;
        end else if (step_i) begin
            state_d = lfsr_next(state_q);
        end
    end

    // State register, resets to the canonical non-zero value 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LFSR_W'(1);
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/constraint_sampler_tx.sv
// Transmit side of the constraint-evaluator link: presents LFSR candidates to an
// external combinational evaluator and forwards those passing every enabled
// constraint over a valid/ready stream.
// Define SAMPLER_STATS_EN to add the saturating attempts/rejects counters.
module constraint_sampler_tx
    import constraint_sampler_pkg::*;
#(
    parameter int NUM_CONS  = 8,
    parameter int MAX_TRIES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    input  logic [LFSR_W-1:0]    seed,
    input  logic [NUM_CONS-1:0]  cons_mask,
    output logic [VAR0_W-1:0]    cand_var_0,
    output logic [VAR1_W-1:0]    cand_var_1,
    output logic [VAR2_W-1:0]    cand_var_2,
    output logic [VAR3_W-1:0]    cand_var_3,
    output logic [VAR4_W-1:0]    cand_var_4,
    input  logic [NUM_CONS-1:0]  cons_in,
    constraint_sampler_if.master samp,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout
`ifdef SAMPLER_STATS_EN
    ,
    output logic [31:0]          attempts,
    output logic [31:0]          rejects
`endif
);

    // Wide enough to hold MAX_TRIES-1 even when MAX_TRIES is 1
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    state_t               state_q;
    logic [NUM_CONS-1:0]  mask_q;
    logic [CNT_W-1:0]     num_q;
    logic [CNT_W-1:0]     count_q;
    logic [TRY_W-1:0]     tries_q;
    logic                 timeout_q;
    logic                 done_q;
    logic                 busy_q;
    logic                 samp_valid_q;
    sample_t              samp_q;

    logic [LFSR_W-1:0]    lfsr_state;
    logic                 lfsr_load;
    logic                 lfsr_step;
    logic                 lfsr_unused;
    sample_t              cand;
    logic                 pass;

    // The LFSR only moves while attempting, so sink stalls never alter the sequence
    assign lfsr_load = (state_q == IDLE) && start;
    assign lfsr_step = (state_q == TRY);

    sampler_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (lfsr_load),
        .seed_i  (seed),
        .step_i  (lfsr_step),
        .state_o (lfsr_state)
    );

    assign cand        = sample_t'(lfsr_state[SAMPLE_W-1:0]);
    assign lfsr_unused = ^lfsr_state[LFSR_W-1:SAMPLE_W];

    assign cand_var_0 = cand.var_0;
    assign cand_var_1 = cand.var_1;
    assign cand_var_2 = cand.var_2;
    assign cand_var_3 = cand.var_3;
    assign cand_var_4 = cand.var_4;

    // A disabled constraint always counts as satisfied
    assign pass = &(cons_in | ~mask_q);

    // Run control: attempt, emit, and finish; all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            num_q        <= '0;
            count_q      <= '0;
            tries_q      <= '0;
            timeout_q    <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            samp_valid_q <= 1'b0;
            samp_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mask_q    <= cons_mask;
                        num_q     <= num_samples;
                        count_q   <= '0;
                        tries_q   <= '0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= (num_samples == '0) ? DONE : TRY;
                    end
                end
                TRY: begin
                    if (pass) begin
                        samp_q       <= cand;
                        samp_valid_q <= 1'b1;
                        tries_q      <= '0;
                        state_q      <= EMIT;
                    end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        tries_q <= tries_q + TRY_W'(1);
                    end
                end
                EMIT: begin
                    if (samp.samp_ready) begin
                        samp_valid_q <= 1'b0;
                        count_q      <= count_q + CNT_W'(1);
                        state_q      <= ((count_q + CNT_W'(1)) == num_q) ? DONE : TRY;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign samp.samp_valid = samp_valid_q;
    assign samp.samp_var_0 = samp_q.var_0;
    assign samp.samp_var_1 = samp_q.var_1;
    assign samp.samp_var_2 = samp_q.var_2;
    assign samp.samp_var_3 = samp_q.var_3;
    assign samp.samp_var_4 = samp_q.var_4;

    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;

`ifdef SAMPLER_STATS_EN
    logic [31:0] attempts_q;
    logic [31:0] rejects_q;

    // Per-run attempt and reject counters, cleared on start, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            attempts_q <= '0;
            rejects_q  <= '0;
        end else if ((state_q == IDLE) && start) begin
            attempts_q <= '0;
            rejects_q  <= '0;
        end else if (state_q == TRY) begin
            if (attempts_q != '1) begin
                attempts_q <= attempts_q + 32'd1;
            end
            if (!pass && (rejects_q != '1)) begin
                rejects_q <= rejects_q + 32'd1;
            end
        end
    end

    assign attempts = attempts_q;
    assign rejects  = rejects_q;
`endif

endmodule

// File: tb/tb_constraint_sampler_tx.sv
// Directed bench for constraint_sampler_tx: two instances share stimulus, one with
// MAX_TRIES=1024 (evaluator passes when var_4==0) and one with MAX_TRIES=16
// (evaluator never passes).
module tb_constraint_sampler_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num = '0;
    logic [63:0] seed = '0;
    logic [7:0]  mask = '0;
    logic        rdy = 1'b0;

    always #5 clk = ~clk;

    logic [12:0] ca0, ca1, cb0, cb1;
    logic [13:0] ca2, ca3, cb2, cb3;
    logic [7:0]  ca4, cb4;
    logic [7:0]  cons_a, cons_b;
    logic        busy_a, done_a, to_a, busy_b, done_b, to_b;
`ifdef SAMPLER_STATS_EN
    logic [31:0] att_a, rej_a, att_b, rej_b;
`endif

    assign cons_a = {7'b0, (ca4 == 8'h00)};
    assign cons_b = 8'h00;

    constraint_sampler_if sif_a ();
    constraint_sampler_if sif_b ();
    assign sif_a.samp_ready = rdy;
    assign sif_b.samp_ready = rdy;

    constraint_sampler_tx #(.NUM_CONS(8), .MAX_TRIES(1024), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num), .seed(seed),
        .cons_mask(mask), .cand_var_0(ca0), .cand_var_1(ca1), .cand_var_2(ca2),
        .cand_var_3(ca3), .cand_var_4(ca4), .cons_in(cons_a), .samp(sif_a),
        .busy(busy_a), .done(done_a), .timeout(to_a)
`ifdef SAMPLER_STATS_EN
        , .attempts(att_a), .rejects(rej_a)
`endif
    );

    constraint_sampler_tx #(.NUM_CONS(8), .MAX_TRIES(16), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num), .seed(seed),
        .cons_mask(mask), .cand_var_0(cb0), .cand_var_1(cb1), .cand_var_2(cb2),
        .cand_var_3(cb3), .cand_var_4(cb4), .cons_in(cons_b), .samp(sif_b),
        .busy(busy_b), .done(done_b), .timeout(to_b)
`ifdef SAMPLER_STATS_EN
        , .attempts(att_b), .rejects(rej_b)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Handshake monitor, sampled on the falling edge
    logic [63:0] got_a[$];
    int          vld_a_seen = 0;
    int          vld_b_seen = 0;
    always @(negedge clk) begin
        if (sif_a.samp_valid && sif_a.samp_ready)
            got_a.push_back({2'b00, sif_a.samp_var_4, sif_a.samp_var_3, sif_a.samp_var_2,
                             sif_a.samp_var_1, sif_a.samp_var_0});
        if (sif_a.samp_valid) vld_a_seen++;
        if (sif_b.samp_valid) vld_b_seen++;
    end

    function automatic logic [63:0] got_at(input int k);
        return (k < got_a.size()) ? got_a[k] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [63:0] cand_a();
        return {2'b00, ca4, ca3, ca2, ca1, ca0};
    endfunction

    // Reference LFSR written as an explicit shift with feedback into tap positions
    function automatic logic [63:0] nxt(input logic [63:0] s);
        logic [63:0] n;
        logic        fb;
        fb = s[0];
        n  = {fb, s[63:1]};
        n[62] = n[62] ^ fb;
        n[60] = n[60] ^ fb;
        n[59] = n[59] ^ fb;
        return n;
    endfunction

    logic [63:0] exp_s[$];
    bit          exp_to;
    int          exp_att;

    task automatic model(input logic [63:0] sd, input bit need4, input int n, input int maxt);
        logic [63:0] s;
        int          tries;
        bit          got;
        exp_s.delete();
        exp_to  = 0;
        exp_att = 0;
        s = (sd == 64'd0) ? 64'd1 : sd;
        for (int k = 0; k < n && !exp_to; k++) begin
            tries = 0;
            got   = 0;
            while (!got && !exp_to) begin
                exp_att++;
                if (!need4 || s[61:54] == 8'h00) begin
                    exp_s.push_back({2'b00, s[61:0]});
                    got = 1;
                end else begin
                    tries++;
                    if (tries == maxt) exp_to = 1;
                end
                s = nxt(s);
            end
        end
    endtask

    task automatic run(input logic [63:0] sd, input logic [7:0] mk, input logic [15:0] n);
        got_a.delete();
        vld_a_seen = 0;
        vld_b_seen = 0;
        @(posedge clk); #1;
        seed = sd; mask = mk; num = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, output int cyc);
        cyc = 0;
        while (!done_a && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_a_seen", {63'b0, done_a}, 64'd1);
    endtask

    task automatic settle();
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("settle_idle", {63'b0, busy_a | busy_b}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        logic [63:0] sd;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'b0, sif_a.samp_valid}, 64'd0);
        chk("rst_busy", {63'b0, busy_a}, 64'd0);
        chk("rst_done", {63'b0, done_a}, 64'd0);
        chk("rst_timeout", {63'b0, to_a}, 64'd0);
        chk("rst_samp", {51'b0, sif_a.samp_var_0}, 64'd0);
        chk("rst_cand", cand_a(), 64'd1);
        @(negedge clk) rst_n = 1'b1;

        // Mask 0, three samples back to back
        sd = 64'h0123_4567_89AB_CDEF;
        rdy = 1'b1;
        model(sd, 1'b0, 3, 1024);
        run(sd, 8'h00, 16'd3);
        chk("t1_busy", {63'b0, busy_a}, 64'd1);
        chk("t1_cand0", cand_a(), exp_s[0]);
        wait_done_a(100, cyc);
        chk("t1_done_cyc", cyc, 64'd7);
        chk("t1_count", got_a.size(), 64'd3);
        chk("t1_s0_v0", {51'b0, got_at(0)[12:0]}, 64'h0DEF);
        for (int k = 0; k < 3; k++) chk("t1_sample", got_at(k), exp_s[k]);
        chk("t1_timeout", {63'b0, to_a}, 64'd0);
        settle();

        // Only var_4 == 0 passes
        sd = 64'hFEED_FACE_CAFE_BEEF;
        model(sd, 1'b1, 2, 1024);
        run(sd, 8'h01, 16'd2);
        wait_done_a(6000, cyc);
        chk("t2_count", got_a.size(), exp_s.size());
        for (int k = 0; k < exp_s.size(); k++) chk("t2_sample", got_at(k), exp_s[k]);
        for (int k = 0; k < got_a.size(); k++) chk("t2_var4", {56'b0, got_at(k)[61:54]}, 64'd0);
        chk("t2_timeout", {63'b0, to_a}, {63'b0, exp_to});
`ifdef SAMPLER_STATS_EN
        chk("t2_attempts", att_a, exp_att);
        chk("t2_rejects", rej_a, exp_att - exp_s.size());
`endif
        settle();

        // Evaluator never passes on the MAX_TRIES=16 instance
        run(64'h5, 8'h01, 16'd1);
        cyc = 0;
        while (!done_b && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t3_done_seen", {63'b0, done_b}, 64'd1);
        chk("t3_done_cyc", cyc, 64'd17);
        chk("t3_timeout", {63'b0, to_b}, 64'd1);
`ifdef SAMPLER_STATS_EN
        chk("t3_attempts", att_b, 64'd16);
        chk("t3_rejects", rej_b, 64'd16);
`endif
        settle();
        chk("t3_no_valid", vld_b_seen, 64'd0);
        chk("t3_sticky", {63'b0, to_b}, 64'd1);

        // Sink stall for 20 cycles; a start during the run is ignored
        sd = 64'hA5A5_5A5A_0F0F_F0F0;
        rdy = 1'b0;
        model(sd, 1'b0, 2, 1024);
        run(sd, 8'h00, 16'd2);
        chk("t4_timeout_clr", {63'b0, to_b}, 64'd0);
        cyc = 0;
        while (!sif_a.samp_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t4_valid_cyc", cyc, 64'd1);
        seed = 64'h1111_2222_3333_4444;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            chk("t4_stall_valid", {63'b0, sif_a.samp_valid}, 64'd1);
            chk("t4_stall_samp", {2'b00, sif_a.samp_var_4, sif_a.samp_var_3, sif_a.samp_var_2,
                                  sif_a.samp_var_1, sif_a.samp_var_0}, exp_s[0]);
            chk("t4_stall_cand", cand_a(), exp_s[1]);
        end
        rdy = 1'b1;
        wait_done_a(100, cyc);
        chk("t4_count", got_a.size(), 64'd2);
        for (int k = 0; k < 2; k++) chk("t4_sample", got_at(k), exp_s[k]);
        settle();

        // num = 0 finishes without attempting
        run(64'h42, 8'h00, 16'd0);
        wait_done_a(20, cyc);
        chk("t5_done_cyc", cyc, 64'd1);
        settle();
        chk("t5_no_valid", vld_a_seen, 64'd0);

        // Zero seed behaves as seed 1
        run(64'h0, 8'h00, 16'd1);
        wait_done_a(20, cyc);
        chk("t5_seed0", got_at(0), 64'd1);
        settle();

        // Reset during EMIT, then rerun with the same seed
        sd = 64'h1357_9BDF_2468_ACE0;
        rdy = 1'b0;
        model(sd, 1'b0, 1, 1024);
        run(sd, 8'h00, 16'd1);
        cyc = 0;
        while (!sif_a.samp_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t6_valid", {63'b0, sif_a.samp_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {63'b0, sif_a.samp_valid}, 64'd0);
        chk("t6_rst_samp", {2'b00, sif_a.samp_var_4, sif_a.samp_var_3, sif_a.samp_var_2,
                            sif_a.samp_var_1, sif_a.samp_var_0}, 64'd0);
        chk("t6_rst_busy", {63'b0, busy_a}, 64'd0);
        chk("t6_rst_cand", cand_a(), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t6_no_done", {63'b0, done_a}, 64'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        rdy = 1'b1;
        run(sd, 8'h00, 16'd1);
        wait_done_a(50, cyc);
        chk("t6_rerun", got_at(0), exp_s[0]);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
